// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
//
// Instruction fetch stage with a small prefetch FIFO. Owns the fetch PC,
// presents one word-aligned address per cycle to a combinational instruction
// memory, buffers up to DEPTH fetched words (each tagged with its PC) and hands
// them to decode over a valid/ready handshake. A redirect flushes everything
// and restarts fetch at the new PC.
//
// Parameters:
//   DEPTH     queue entries, power of two, >= 2
//   RESET_PC  first fetch address after reset, word aligned
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset        synchronous, active-high reset
//   imem_addr    byte address to instruction memory (always the fetch PC)
//   imem_rdata   instruction word at imem_addr, valid in the same cycle
//   imem_stall   high = imem_rdata not valid this cycle, nothing is fetched
//   redirect     flush the queue and restart fetch at redirect_pc
//   redirect_pc  new fetch address, bits [1:0] ignored
//   inst_valid   head entry present
//   inst_ready   consumer accepts the head entry this cycle
//   inst         head instruction word
//   inst_pc      PC of the head instruction
//   count        current occupancy, 0..DEPTH
//
// Optional feature (macro FETCHQ_PERF_EN):
//   perf_fetched  32-bit wrapping count of words pushed into the queue
//   perf_stall    32-bit wrapping count of cycles with imem_stall high
//   perf_flush    32-bit wrapping count of redirect cycles
//   All three are cleared by reset. Without the macro they do not exist.
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [31:0]           imem_addr,
    input  logic [31:0]           imem_rdata,
    input  logic                  imem_stall,
    input  logic                  redirect,
    input  logic [31:0]           redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [31:0]           inst,
    output logic [31:0]           inst_pc,
    output logic [$clog2(DEPTH):0] count
`ifdef FETCHQ_PERF_EN
    ,
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_stall,
    output logic [31:0]           perf_flush
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Fetch PC and queue bookkeeping
    logic [31:0]      fetch_pc;
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;

    // Entry storage, split into word and PC arrays indexed by the same pointer
    logic [31:0]      word_mem [DEPTH];
    logic [31:0]      pc_mem   [DEPTH];

    // Last head value shown to the consumer, presented while the queue is empty
    logic [31:0]      hold_inst;
    logic [31:0]      hold_pc;

    logic             full;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] push_ext;
    logic [CNT_W-1:0] pop_ext;

    // The low address bits of a redirect target are dropped on purpose;
    // fetch is always word aligned.
    logic             unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign imem_addr = fetch_pc;

    // Handshake decode. A redirect cancels both sides: the consumer's accept
    // in that cycle is ignored and nothing is fetched. When full, a fetch is
    // only taken if the head is leaving in the same cycle.
    always_comb begin
        full       = (count == CNT_W'(DEPTH));
        inst_valid = (count != '0);
        pop        = inst_valid & inst_ready & ~redirect;
        push       = ~reset & ~redirect & ~imem_stall & (~full | pop);
        push_ext   = {{(CNT_W-1){1'b0}}, push};
        pop_ext    = {{(CNT_W-1){1'b0}}, pop};
    end

    // Head presentation. With no entry present the outputs fall back to the
    // last head value so they never go undefined once reset has been applied.
    always_comb begin
        if (inst_valid) begin
            inst    = word_mem[head_ptr];
            inst_pc = pc_mem[head_ptr];
        end else begin
            inst    = hold_inst;
            inst_pc = hold_pc;
        end
    end

    // Fetch PC, pointers and occupancy. Reset beats redirect, redirect beats
    // the normal push/pop update. Pointers wrap naturally since DEPTH is a
    // power of two; the PC add wraps modulo 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
                tail_ptr <= tail_ptr + PTR_W'(1);
            end
            if (pop) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
            count <= count + push_ext - pop_ext;
        end
    end

    // Entry write at the tail. Push already excludes reset and redirect, so
    // the storage itself needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            word_mem[tail_ptr] <= imem_rdata;
            pc_mem[tail_ptr]   <= fetch_pc;
        end
    end

    // Track what the consumer currently sees so it can be held once the
    // queue runs dry or is flushed.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_inst <= '0;
            hold_pc   <= '0;
        end else if (inst_valid) begin
            hold_inst <= word_mem[head_ptr];
            hold_pc   <= pc_mem[head_ptr];
        end
    end

`ifdef FETCHQ_PERF_EN
    // Performance counters, free-running and wrapping on overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
            perf_flush   <= '0;
        end else begin
            perf_fetched <= perf_fetched + 32'(push);
            perf_stall   <= perf_stall + 32'(imem_stall);
            perf_flush   <= perf_flush + 32'(redirect);
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_queue
//
// Self-checking bench for inst_fetch_queue (DEPTH=4, RESET_PC=0). The
// instruction memory is a pure function of the address. A queue-based
// reference model tracks the fetch PC, the buffered entries and the held head
// value; every cycle the DUT outputs are compared against it. Directed
// scenarios are followed by a long randomized run. Define FETCHQ_PERF_EN to
// also check the performance counters.
// -----------------------------------------------------------------------------
module tb_inst_fetch_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    logic        clk;
    logic        reset;
    logic [31:0] imemAddr;
    logic [31:0] imemRdata;
    logic        imemStall;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        instValid;
    logic        instReady;
    logic [31:0] inst;
    logic [31:0] instPc;
    logic [2:0]  count;
`ifdef FETCHQ_PERF_EN
    logic [31:0] perfFetched;
    logic [31:0] perfStall;
    logic [31:0] perfFlush;
`endif

    // Reference model state
    entry_t      modelQ[$];
    logic [31:0] modelPc;
    logic [31:0] modelHoldInst;
    logic [31:0] modelHoldPc;
    logic [31:0] modelFetched;
    logic [31:0] modelStalls;
    logic [31:0] modelFlushes;
    bit          modelSynced;

    int vectorCount;
    int missCount;

    // Clock generation, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory content, derived from the address alone
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        logic [15:0] lo;
        logic [15:0] hi;
        lo = addr[15:0] ^ 16'hC3A5;
        hi = addr[31:16] + addr[7:0] + 16'h1234;
        return {hi, lo};
    endfunction

    assign imemRdata = memWord(imemAddr);

    inst_fetch_queue #(
        .DEPTH   (DEPTH),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imemAddr),
        .imem_rdata (imemRdata),
        .imem_stall (imemStall),
        .redirect   (redirect),
        .redirect_pc(redirectPc),
        .inst_valid (instValid),
        .inst_ready (instReady),
        .inst       (inst),
        .inst_pc    (instPc),
        .count      (count)
`ifdef FETCHQ_PERF_EN
        ,
        .perf_fetched(perfFetched),
        .perf_stall  (perfStall),
        .perf_flush  (perfFlush)
`endif
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h expected %h at time %0t",
                     tag, actual, expected, $time);
        end
    endtask

    // Compare all DUT outputs against the model's view of the current cycle
    task automatic compareAll();
        logic [31:0] expInst;
        logic [31:0] expPc;
        checkOutput("imem_addr", imemAddr, modelPc);
        checkOutput("inst_valid", {31'd0, instValid}, {31'd0, modelQ.size() != 0});
        checkOutput("count", {29'd0, count}, modelQ.size());
        if (modelQ.size() != 0) begin
            expInst = modelQ[0].word;
            expPc   = modelQ[0].pc;
        end else begin
            expInst = modelHoldInst;
            expPc   = modelHoldPc;
        end
        checkOutput("inst", inst, expInst);
        checkOutput("inst_pc", instPc, expPc);
`ifdef FETCHQ_PERF_EN
        checkOutput("perf_fetched", perfFetched, modelFetched);
        checkOutput("perf_stall", perfStall, modelStalls);
        checkOutput("perf_flush", perfFlush, modelFlushes);
`endif
    endtask

    // Advance the model by one clock edge using the rules of the stage
    task automatic modelStep(input logic rst, input logic rd,
                             input logic [31:0] rdPc, input logic stall,
                             input logic ready);
        bit taken;
        bit fetched;
        if (rst) begin
            modelQ.delete();
            modelPc       = 32'h0;
            modelHoldInst = 32'h0;
            modelHoldPc   = 32'h0;
            modelFetched  = 32'h0;
            modelStalls   = 32'h0;
            modelFlushes  = 32'h0;
            modelSynced   = 1'b1;
        end else begin
            if (modelQ.size() != 0) begin
                modelHoldInst = modelQ[0].word;
                modelHoldPc   = modelQ[0].pc;
            end
            if (stall) modelStalls++;
            if (rd) begin
                modelFlushes++;
                modelQ.delete();
                modelPc = {rdPc[31:2], 2'b00};
            end else begin
                taken   = (modelQ.size() != 0) && ready;
                fetched = !stall && ((modelQ.size() < DEPTH) || taken);
                if (taken) void'(modelQ.pop_front());
                if (fetched) begin
                    modelQ.push_back('{pc: modelPc, word: memWord(modelPc)});
                    modelPc = modelPc + 32'd4;
                    modelFetched++;
                end
            end
        end
    endtask

    // Drive one cycle of inputs away from the clock edge, check, then model
    task automatic applyStimulus(input logic rst, input logic rd,
                                 input logic [31:0] rdPc, input logic stall,
                                 input logic ready);
        @(negedge clk);
        reset      = rst;
        redirect   = rd;
        redirectPc = rdPc;
        imemStall  = stall;
        instReady  = ready;
        #1;
        if (modelSynced) compareAll();
        modelStep(rst, rd, rdPc, stall, ready);
    endtask

    // Sample after the following edge has settled
    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] rpc;
        bit          rr;
        bit          rd;
        bit          st;
        bit          rdy;

        vectorCount = 0;
        missCount   = 0;
        modelSynced = 1'b0;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirectPc  = 32'h0;
        imemStall   = 1'b0;
        instReady   = 1'b0;

        // Scenario 1: reset, then free-running consumer
        applyStimulus(1, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 1);

        // Scenario 2: consumer stalled until the queue fills, then drains
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 0);
        settle();
        checkOutput("full_count", {29'd0, count}, 32'd4);
        checkOutput("full_addr", imemAddr, 32'h10);
        checkOutput("full_head_pc", instPc, 32'h0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 1);

        // Scenario 3: three entries queued, then redirect to unaligned target
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 1, 32'h203, 0, 1);
        settle();
        checkOutput("redir_addr", imemAddr, 32'h200);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1);

        // Scenario 4: memory stall with a ready consumer, then resume
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 1);

        // Scenario 5: PC wrap at the top of the address space
        applyStimulus(0, 1, 32'hFFFF_FFF8, 0, 1);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 1);

        // Scenario 6: stall burst followed by one redirect (perf counters)
        applyStimulus(1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 1, 32'h40, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1);

        // Randomized run
        for (int i = 0; i < 3000; i++) begin
            rr  = ($urandom_range(99) == 0);
            rd  = ($urandom_range(15) == 0);
            st  = ($urandom_range(3) == 0);
            rdy = ($urandom_range(2) != 0);
            if ($urandom_range(3) == 0)
                rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            else
                rpc = $urandom;
            applyStimulus(rr, rd, rpc, st, rdy);
        end

        settle();
        compareAll();
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
Instruction fetch stage with a prefetch FIFO. It sits between the combinational instruction-memory read port and the core's decode stage. It owns the fetch PC and issues one word-aligned address per cycle to instruction memory. It buffers up to DEPTH fetched words, each tagged with its PC, and hands them to the core over a valid/ready handshake. A redirect (branch/jump/trap) flushes the queue and restarts fetch at a new PC.

Parameters:
DEPTH, 4, queue entries; power of two, >= 2
RESET_PC, 32'h0000_0000, first fetch address after reset; must be word aligned

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_addr  output  32  byte address to instruction memory; always equals fetch_pc
imem_rdata  input  32  instruction word at imem_addr, valid in the same cycle (combinational memory)
imem_stall  input  1  high = imem_rdata not valid this cycle; no fetch occurs
redirect  input  1  flush queue and restart fetch at redirect_pc
redirect_pc  input  32  new fetch address; bits [1:0] are ignored
inst_valid  output  1  head entry present
inst_ready  input  1  consumer accepts head entry this cycle
inst  output  32  head instruction word
inst_pc  output  32  PC of head instruction
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset (sampled at a clk edge while reset=1):
  - fetch_pc <= RESET_PC; queue emptied; count=0.
  - Outputs during and after reset: inst_valid=0, imem_addr=RESET_PC, inst=0, inst_pc=0.
  - Reset overrides redirect and all handshakes.
- Signal definitions:
  - pop = inst_valid & inst_ready & !redirect.
  - push = !reset & !redirect & !imem_stall & (count<DEPTH | pop).
- On push:
  - Entry {fetch_pc, imem_rdata} is written at the tail.
  - fetch_pc <= fetch_pc + 4, mod 2^32; 32'hFFFF_FFFC wraps to 0.
- On pop: head advances.
- count update: count <= count + push - pop. Push and pop in the same cycle leave count unchanged.
- Full (count==DEPTH):
  - Push is allowed only if pop occurs in the same cycle.
  - Otherwise fetch_pc holds and imem_addr is unchanged.
- Empty: inst_valid=0. There is no same-cycle bypass; minimum latency from fetch to inst_valid is 1 cycle.
- inst_valid = (count!=0). inst and inst_pc come from the head entry and are stable while inst_valid=1 and inst_ready=0.
- When count==0, inst and inst_pc hold their last values. They are don't-care, but must not be X after reset.
- Redirect cycle:
  - Queue cleared (count<=0), no push, no pop.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - inst_valid falls in the next cycle.
  - A consumer handshake in the redirect cycle is discarded, i.e. the head is not considered consumed.
- imem_stall=1: no push, fetch_pc holds; pop proceeds normally.
- Throughput: 1 instruction/cycle sustained with no stalls and inst_ready=1.
- Pointers are $clog2(DEPTH) bits and wrap naturally.

Optional Feature:
Macro: FETCHQ_PERF_EN.
- Defined:
  - Three extra output ports, each 32 bits and wrapping on overflow, all cleared by reset:
    - perf_fetched: increments on each push.
    - perf_stall: increments on each cycle with imem_stall=1 and !reset.
    - perf_flush: increments on each cycle with redirect=1 and !reset.
- Not defined: ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset release, imem_rdata = address-derived pattern, inst_ready=1 -> inst_valid rises 1 cycle after reset deasserts; inst_pc sequence 0,4,8,12 on consecutive cycles; count stays 1.
2. inst_ready=0 for 10 cycles after reset -> count reaches 4 (DEPTH=4) and holds; imem_addr holds at 0x10; inst_pc stays 0x0. Then inst_ready=1 -> pops 0x0,0x4,0x8,0xC,0x10 back-to-back with no bubble.
3. Queue holding 3 entries, redirect=1 with redirect_pc=0x203 -> next cycle count=0, inst_valid=0, imem_addr=0x200. The following cycle inst_pc=0x200.
4. imem_stall=1 for 3 cycles with inst_ready=1 -> queue drains; imem_addr frozen; no entries for the stalled addresses. After the stall, fetch resumes at the frozen address with no duplicated or skipped PC.
5. redirect_pc=0xFFFF_FFF8, free-running -> inst_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
6. With FETCHQ_PERF_EN: run scenario 4 followed by one redirect -> perf_stall=3 and perf_flush=1; perf_fetched equals the number of pushes counted by the bench.
